// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg                                                              |
// | Shared constants and FSM encoding for the divider unit.              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cpu_pkg;

    localparam int unsigned c_default_width = 16;
    localparam int unsigned c_cnt_w         = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_step                                                             |
// | One combinational restoring-division step (shift, trial subtract).   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module div_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] dvd,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] dvd_next
);

    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_diff;
    logic           w_neg;

    // rem < divisor holds, so the WIDTH+1-bit difference MSB is a clean sign bit
    assign w_rem_sh = {rem, dvd[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, divisor};
    assign w_neg    = w_diff[WIDTH];

    assign rem_next = w_neg ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign dvd_next = {dvd[WIDTH-2:0], ~w_neg};

endmodule

`default_nettype wire

// File: rtl/divider_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | divider_unit                                                         |
// | Sequential unsigned restoring divider, one quotient bit per cycle.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module divider_unit
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_zero
);

    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    div_state_t         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_div;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_dvd_next;

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem      (r_rem),
        .dvd      (r_dvd),
        .divisor  (r_div),
        .rem_next (w_rem_next),
        .dvd_next (w_dvd_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_dvd    <= '0;
            r_div    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            q        <= '0;
            r        <= '0;
            div_zero <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_dvd <= a;
                        r_div <= b;
                        r_rem <= '0;
                        r_cnt <= c_cnt_load;
                        busy  <= 1'b1;
                        // Division by zero short-circuits straight to a result
                        if (b == '0) begin
                            r_state  <= ST_DONE;
                            done     <= 1'b1;
                            q        <= '1;
                            r        <= a;
                            div_zero <= 1'b1;
                        end else begin
                            r_state  <= ST_CALC;
                            div_zero <= 1'b0;
                        end
                    end
                end
                ST_CALC: begin
                    r_rem <= w_rem_next;
                    r_dvd <= w_dvd_next;
                    r_cnt <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                        q       <= w_dvd_next;
                        r       <= w_rem_next;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_divider_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_divider_unit                                                      |
// | Directed-vector and random self-checking bench for divider_unit.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_divider_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] q;
    logic [15:0] r;
    logic        div_zero;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
    } vec_t;

    vec_t vecs [12];

    divider_unit #(
        .WIDTH (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .q        (q),
        .r        (r),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle and check latency, busy, and the result.
    task automatic run_div(input logic [15:0] av, input logic [15:0] bv,
                           input logic [15:0] eq, input logic [15:0] er,
                           input logic edz, input string tag);
        int cyc;
        int busy_ok;
        int exp_lat;
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start   = 1'b0;
        cyc     = 1;
        busy_ok = 1;
        exp_lat = (bv == 16'd0) ? 1 : 17;
        while (!done && cyc < 40) begin
            if (!busy) busy_ok = 0;
            tick();
            cyc++;
        end
        if (!busy) busy_ok = 0;
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_busy"}, 32'(busy_ok), 32'd1);
        check({tag, "_q"}, 32'(q), 32'(eq));
        check({tag, "_r"}, 32'(r), 32'(er));
        check({tag, "_dz"}, 32'(div_zero), 32'(edz));
        tick();
        check({tag, "_done_1cyc"}, 32'(done), 32'd0);
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        int first_done;
        int cnt_done;
        int cnt_busy;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] eq;
        logic [15:0] er;
        int sel;

        n_tests = 0;
        n_fail  = 0;
        vecs[0]  = '{16'd100,   16'd7,     16'd14,    16'd2,   1'b0};
        vecs[1]  = '{16'hFFFF,  16'd1,     16'hFFFF,  16'd0,   1'b0};
        vecs[2]  = '{16'd3,     16'd10,    16'd0,     16'd3,   1'b0};
        vecs[3]  = '{16'd5,     16'd0,     16'hFFFF,  16'd5,   1'b1};
        vecs[4]  = '{16'd9,     16'd3,     16'd3,     16'd0,   1'b0};
        vecs[5]  = '{16'd20,    16'd6,     16'd3,     16'd2,   1'b0};
        vecs[6]  = '{16'hFFFF,  16'hFFFF,  16'd1,     16'd0,   1'b0};
        vecs[7]  = '{16'd0,     16'd5,     16'd0,     16'd0,   1'b0};
        vecs[8]  = '{16'hFFFF,  16'd2,     16'h7FFF,  16'd1,   1'b0};
        vecs[9]  = '{16'd1000,  16'd33,    16'd30,    16'd10,  1'b0};
        vecs[10] = '{16'h8000,  16'h0100,  16'h0080,  16'd0,   1'b0};
        vecs[11] = '{16'd12345, 16'd1000,  16'd12,    16'd345, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_q", 32'(q), 32'd0);
        check("reset_r", 32'(r), 32'd0);
        check("reset_dz", 32'(div_zero), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz,
                    $sformatf("vec%0d", i));
        end

        // start and new operands during CALC/DONE must be ignored
        a = 16'd100; b = 16'd7; start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        tick(); tick();
        cyc   = 3;
        a = 16'd50; b = 16'd5; start = 1'b1;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
        start = 1'b0;
        check("ign_latency", 32'(cyc), 32'd17);
        check("ign_q", 32'(q), 32'd14);
        check("ign_r", 32'(r), 32'd2);
        cnt_done = 0;
        cnt_busy = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) cnt_done++;
            if (busy) cnt_busy++;
        end
        check("ign_extra_done", 32'(cnt_done), 32'd0);
        check("ign_busy_after", 32'(cnt_busy), 32'd0);
        check("ign_q_hold", 32'(q), 32'd14);

        // start held high gives back-to-back operations, 18 cycles apart
        a = 16'd9; b = 16'd3; start = 1'b1;
        tick();
        cyc = 1;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
        check("b2b_first_lat", 32'(cyc), 32'd17);
        first_done = cyc;
        tick();
        cyc++;
        check("b2b_idle_busy", 32'(busy), 32'd0);
        tick();
        cyc++;
        check("b2b_reaccept_busy", 32'(busy), 32'd1);
        while (!done && cyc < 80) begin
            tick();
            cyc++;
        end
        start = 1'b0;
        check("b2b_spacing", 32'(cyc - first_done), 32'd18);
        check("b2b_q", 32'(q), 32'd3);
        tick();

        // asynchronous reset in cycle 8 aborts the operation
        a = 16'd100; b = 16'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_q", 32'(q), 32'd0);
        check("arst_r", 32'(r), 32'd0);
        check("arst_dz", 32'(div_zero), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        cnt_done = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) cnt_done++;
        end
        check("arst_no_done", 32'(cnt_done), 32'd0);
        run_div(16'd20, 16'd6, 16'd3, 16'd2, 1'b0, "post_rst");

        // random stress against a reference model
        for (int i = 0; i < 1000; i++) begin
            ra  = 16'($urandom);
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      rb = 16'd0;
            else if (sel == 1) rb = 16'd1;
            else if (sel == 2) rb = 16'($urandom_range(1, 15));
            else               rb = 16'($urandom);
            if (rb == 16'd0) begin
                eq = 16'hFFFF;
                er = ra;
            end else begin
                eq = ra / rb;
                er = ra % rb;
            end
            run_div(ra, rb, eq, er, (rb == 16'd0), "rand");
            if (rb != 16'd0) begin
                check("rand_identity", 32'(q) * 32'(rb) + 32'(r), 32'(ra));
                check("rand_r_lt_b", 32'(r < rb), 32'd1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
